// File: rtl/mips_dmem_mmio.sv
// Data-side memory responder for the pipelined MIPS core: word RAM plus an MMIO
// window holding a free-running cycle counter and a byte TX FIFO with valid/ready drain.
module mips_dmem_mmio #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [15:0] OFF_CYCLE  = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rdptr;
    logic [PW-1:0] wrptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycle;

    logic          sel_mmio;
    logic [15:0]   off;
    logic [AW-1:0] ram_idx;
    logic          wr_cycle;
    logic          wr_tx;
    logic          wr_status;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   status;

    // Address decode and per-register strobes
    assign sel_mmio  = (memaddr[31:16] == 16'hFFFF);
    assign off       = memaddr[15:0];
    assign ram_idx   = memaddr[AW+1:2];
    assign wr_cycle  = memwrite && sel_mmio && (off == OFF_CYCLE);
    assign wr_tx     = memwrite && sel_mmio && (off == OFF_TXDATA);
    assign wr_status = memwrite && sel_mmio && (off == OFF_STATUS);

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign push     = wr_tx && !full;
    assign pop      = !empty && tx_ready;
    assign tx_valid = !empty;
    assign tx_data  = fifo[rdptr];

    // RAM is deliberately not reset
    always_ff @(posedge clk) begin
        if (memwrite && !sel_mmio) begin
            ram[ram_idx] <= memwritedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle <= '0;
        end else if (wr_cycle) begin
            cycle <= memwritedata;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    // TX FIFO; a push while full is dropped even if a pop frees a slot this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo[wrptr] <= memwritedata[7:0];
                wrptr       <= wrptr + PW'(1);
            end
            if (pop) begin
                rdptr <= rdptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky overflow; a set on the same edge as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_tx && full) begin
            overflow <= 1'b1;
        end else if (wr_status && memwritedata[2]) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[2]    = overflow;
        status[11:8] = 4'(count);
    end

    always_comb begin
        memreaddata = '0;
        if (sel_mmio) begin
            case (off)
                OFF_CYCLE:  memreaddata = cycle;
                OFF_STATUS: memreaddata = status;
                default:    memreaddata = '0;
            endcase
        end else begin
            memreaddata = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: directed plan steps followed by random
// traffic, all compared against a queue/array reference model.
module tb_mips_dmem_mmio;

    localparam int unsigned RAM_WORDS = 64;
    localparam int unsigned DEPTH     = 4;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mram [RAM_WORDS];
    bit          mvalid [RAM_WORDS];
    logic [7:0]  q [$];
    logic [31:0] mcyc;
    bit          movf;

    mips_dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .memaddr(memaddr),
        .memwritedata(memwritedata),
        .memreaddata(memreaddata),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:16] == 16'hFFFF) begin
            case (a[15:0])
                16'h0000: return mcyc;
                16'h0008: return {20'h0, 4'(q.size()), 5'h0, movf,
                                  q.size() == DEPTH, q.size() == 0};
                default:  return 32'h0;
            endcase
        end
        return mram[a[7:2]];
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic rdy);
        bit mmio = (a[31:16] == 16'hFFFF);
        bit pop  = rdy && (q.size() != 0);
        bit full = (q.size() == DEPTH);
        if (we && !mmio) begin
            mram[a[7:2]]   = d;
            mvalid[a[7:2]] = 1'b1;
        end
        if (we && mmio && a[15:0] == 16'h0000) mcyc = d;
        else                                   mcyc = mcyc + 32'd1;
        if (we && mmio && a[15:0] == 16'h0008 && d[2]) movf = 1'b0;
        if (pop) void'(q.pop_front());
        if (we && mmio && a[15:0] == 16'h0004) begin
            if (full) movf = 1'b1;
            else      q.push_back(d[7:0]);
        end
    endtask

    // One cycle: drive at negedge, check pre-edge outputs, advance model at posedge
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input bit chk);
        memwrite     = we;
        memaddr      = a;
        memwritedata = d;
        tx_ready     = rdy;
        #1;
        if (chk && (a[31:16] == 16'hFFFF || mvalid[a[7:2]]))
            chk32("memreaddata", memreaddata, exp_read(a));
        chk32("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk32("tx_data", 32'(tx_data), 32'(q[0]));
        @(posedge clk);
        model_edge(we, a, d, rdy);
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        logic [31:0] a;
        logic [31:0] d;
        int op;
        int idx;

        reset        = 1'b1;
        memwrite     = 1'b0;
        memaddr      = 32'h0;
        memwritedata = 32'h0;
        tx_ready     = 1'b0;
        mcyc = 32'h0;
        movf = 1'b0;
        for (int i = 0; i < int'(RAM_WORDS); i++) mvalid[i] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        memaddr = 32'hFFFF_0008;
        #1;
        chk32("rst_status", memreaddata, 32'h0000_0001);
        chk32("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk32("rst_tx_data", 32'(tx_data), 32'h0);
        step(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, 1'b1);

        // RAM store/load and alias
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1);
        memaddr = 32'h0000_0110;
        #1;
        chk32("ram_alias", memreaddata, 32'hDEAD_BEEF);
        step(1'b0, 32'h0000_0110, 32'h0, 1'b0, 1'b1);

        // Cycle counter wrap
        step(1'b1, 32'hFFFF_0000, 32'hFFFF_FFFE, 1'b0, 1'b0);
        memaddr = 32'hFFFF_0000;
        #1;
        chk32("cyc0", memreaddata, 32'hFFFF_FFFE);
        step(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, 1'b1);
        #1;
        chk32("cyc1", memreaddata, 32'hFFFF_FFFF);
        step(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, 1'b1);
        #1;
        chk32("cyc2", memreaddata, 32'h0000_0000);
        step(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, 1'b1);

        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) step(1'b1, 32'hFFFF_0004, 32'(8'h41 + i), 1'b0, 1'b1);
        memaddr = 32'hFFFF_0008;
        memwrite = 1'b0;
        #1;
        chk32("full_status", memreaddata, 32'h0000_0406);
        chk32("full_head", 32'(tx_data), 32'h41);

        // Drain, then clear overflow
        for (int i = 0; i < 4; i++) begin
            memaddr = 32'hFFFF_0008;
            #1;
            chk32("drain_byte", 32'(tx_data), 32'(8'h41 + i));
            step(1'b0, 32'hFFFF_0008, 32'h0, 1'b1, 1'b1);
        end
        #1;
        chk32("drained_valid", 32'(tx_valid), 32'h0);
        chk32("drained_status", memreaddata, 32'h0000_0005);
        step(1'b1, 32'hFFFF_0008, 32'h0000_0004, 1'b0, 1'b1);
        memaddr = 32'hFFFF_0008;
        memwrite = 1'b0;
        #1;
        chk32("cleared_status", memreaddata, 32'h0000_0001);

        // Simultaneous push/pop with count 2
        step(1'b1, 32'hFFFF_0004, 32'h11, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_0004, 32'h22, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_0004, 32'h55, 1'b1, 1'b1);
        memaddr = 32'hFFFF_0008;
        memwrite = 1'b0;
        #1;
        chk32("pushpop_status", memreaddata, 32'h0000_0200);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            memaddr = 32'hFFFF_0008;
            tx_ready = 1'b1;
            #1;
            if (tx_valid && tx_data == 8'h55) seen = 1'b1;
            step(1'b0, 32'hFFFF_0008, 32'h0, 1'b1, 1'b1);
        end
        chk32("emit_55", 32'(seen), 32'h1);

        // Reset mid-drain, between edges
        step(1'b1, 32'hFFFF_0004, 32'h61, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_0004, 32'h62, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_0004, 32'h63, 1'b1, 1'b0);
        memwrite = 1'b0;
        memaddr  = 32'hFFFF_0008;
        #1;
        reset = 1'b1;
        #1;
        chk32("midrst_valid", 32'(tx_valid), 32'h0);
        chk32("midrst_data", 32'(tx_data), 32'h0);
        chk32("midrst_status", memreaddata, 32'h0000_0001);
        #1;
        reset = 1'b0;
        q.delete();
        mcyc = 32'h0;
        movf = 1'b0;
        step(1'b0, 32'hFFFF_0000, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'hFFFF_0008, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            d  = $urandom;
            case (op)
                0, 1, 2: step(1'b1, $urandom & 32'h0000_0FFC, d, 1'($urandom), 1'b0);
                3: begin
                    idx = int'($urandom_range(0, RAM_WORDS - 1));
                    a = ($urandom & 32'h0000_0F00) | 32'(idx << 2);
                    step(1'b0, a, d, 1'($urandom), 1'b1);
                end
                4, 5: step(1'b1, 32'hFFFF_0004, d, 1'($urandom), 1'b1);
                6: step(1'b1, 32'hFFFF_0008, d, 1'($urandom), 1'b1);
                7: step(1'b1, 32'hFFFF_0000, d, 1'($urandom), 1'b1);
                8: begin
                    a = 32'hFFFF_0000 | (32'($urandom_range(0, 4)) << 2);
                    step(1'b0, a, d, 1'($urandom), 1'b1);
                end
                default: step(1'b1, 32'hFFFF_000C | ($urandom & 32'h0000_0F00), d,
                              1'($urandom), 1'b1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
